// File: rtl/setup_editor.sv
// Time-setup editor: IDLE tracks data_ch, EDIT steps one field at a time,
// COMMIT pulses setup_imp for one cycle, DONE waits for the mode to change.
module setup_editor #(
  parameter int FIELDS = 3,
  parameter int FW = 8,
  parameter logic [FIELDS*FW-1:0] LIMITS = {8'd23, 8'd59, 8'd59},
  parameter logic [1:0] MODE_SETUP = 2'd3,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE = 10_000_000,
  parameter int TIMEOUT = 500_000_000,
  localparam int SW = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [FIELDS*FW-1:0] data_ch,
  input  logic [3:0]           button,
  input  logic [1:0]           rezhim,
  output logic [FIELDS*FW-1:0] setup_data,
  output logic                 setup_imp,
  output logic [SW-1:0]        field_sel,
  output logic                 editing
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT = RW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] LAST_FIELD = SW'(FIELDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [FIELDS*FW-1:0] data_nxt;
  logic [SW-1:0]        fsel_nxt;
  logic [3:0]           sync1, sync2, sync3;
  logic [RW-1:0]        rep_cnt, rep_cnt_nxt;
  logic                 rep_arm, rep_arm_nxt;
  logic                 rep_dir, rep_dir_nxt;
  logic [TW-1:0]        tmo_cnt, tmo_nxt;

  logic [3:0]    edges;
  logic          cancel_e, inc_e, next_e, dec_e;
  logic          hold_inc, hold_dec, rep_hold, rep_step;
  logic          inc_act, dec_act, activity;
  logic [FW-1:0] cur_val, lim, inc_val, dec_val;

  assign edges    = sync2 & ~sync3;
  assign cancel_e = edges[0];
  assign inc_e    = edges[1];
  assign next_e   = edges[2];
  assign dec_e    = edges[3];
  assign hold_inc = sync2[1] & ~sync2[3];
  assign hold_dec = sync2[3] & ~sync2[1];

  // rep_dir: 0 = inc, 1 = dec; repeat only while that button alone stays held
  assign rep_hold = rep_dir ? hold_dec : hold_inc;
  assign rep_step = rep_arm && rep_hold && (rep_cnt == '0);
  assign inc_act  = inc_e | (rep_step & ~rep_dir);
  assign dec_act  = dec_e | (rep_step & rep_dir);
  assign activity = (|edges) | rep_step;

  assign cur_val = setup_data[int'(field_sel)*FW +: FW];
  assign lim     = LIMITS[int'(field_sel)*FW +: FW];
  assign inc_val = (cur_val >= lim) ? '0 : cur_val + FW'(1);
  assign dec_val = ((cur_val == '0) || (cur_val > lim)) ? lim : cur_val - FW'(1);

  assign editing   = (state == S_EDIT);
  assign setup_imp = (state == S_COMMIT);

  always_comb begin
    state_nxt   = state;
    data_nxt    = setup_data;
    fsel_nxt    = field_sel;
    rep_cnt_nxt = rep_cnt;
    rep_arm_nxt = rep_arm;
    rep_dir_nxt = rep_dir;
    tmo_nxt     = tmo_cnt;

    case (state)
      S_IDLE: begin
        data_nxt    = data_ch;
        rep_arm_nxt = 1'b0;
        rep_cnt_nxt = '0;
        if (rezhim == MODE_SETUP) begin
          fsel_nxt  = '0;
          tmo_nxt   = TMO_LOAD;
          state_nxt = S_EDIT;
        end
      end

      S_EDIT: begin
        if (rep_arm && !rep_hold) begin
          rep_arm_nxt = 1'b0;
          rep_cnt_nxt = '0;
        end else if (rep_arm && (rep_cnt != '0)) begin
          rep_cnt_nxt = rep_cnt - RW'(1);
        end

        if (activity) tmo_nxt = TMO_LOAD;
        else if (tmo_cnt != '0) tmo_nxt = tmo_cnt - TW'(1);

        if (rezhim != MODE_SETUP) begin
          rep_arm_nxt = 1'b0;
          rep_cnt_nxt = '0;
          state_nxt   = S_IDLE;
        end else if (cancel_e) begin
          rep_arm_nxt = 1'b0;
          rep_cnt_nxt = '0;
          state_nxt   = S_DONE;
        end else if (next_e) begin
          rep_arm_nxt = 1'b0;
          rep_cnt_nxt = '0;
          if (field_sel < LAST_FIELD) fsel_nxt = field_sel + SW'(1);
          else state_nxt = S_COMMIT;
        end else if (!activity && (tmo_cnt == '0)) begin
          rep_arm_nxt = 1'b0;
          rep_cnt_nxt = '0;
          state_nxt   = S_DONE;
        end else if (inc_act && dec_act) begin
          rep_arm_nxt = 1'b0;
          rep_cnt_nxt = '0;
        end else if (inc_act) begin
          data_nxt[int'(field_sel)*FW +: FW] = inc_val;
          if (inc_e) begin
            rep_arm_nxt = 1'b1;
            rep_dir_nxt = 1'b0;
            rep_cnt_nxt = REP_FIRST;
          end else begin
            rep_cnt_nxt = REP_NEXT;
          end
        end else if (dec_act) begin
          data_nxt[int'(field_sel)*FW +: FW] = dec_val;
          if (dec_e) begin
            rep_arm_nxt = 1'b1;
            rep_dir_nxt = 1'b1;
            rep_cnt_nxt = REP_FIRST;
          end else begin
            rep_cnt_nxt = REP_NEXT;
          end
        end
      end

      S_COMMIT: begin
        rep_arm_nxt = 1'b0;
        rep_cnt_nxt = '0;
        state_nxt   = S_DONE;
      end

      S_DONE: begin
        rep_arm_nxt = 1'b0;
        rep_cnt_nxt = '0;
        if (rezhim != MODE_SETUP) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      setup_data <= '0;
      field_sel  <= '0;
      sync1      <= '0;
      sync2      <= '0;
      sync3      <= '0;
      rep_cnt    <= '0;
      rep_arm    <= 1'b0;
      rep_dir    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      setup_data <= data_nxt;
      field_sel  <= fsel_nxt;
      sync1      <= button;
      sync2      <= sync1;
      sync3      <= sync2;
      rep_cnt    <= rep_cnt_nxt;
      rep_arm    <= rep_arm_nxt;
      rep_dir    <= rep_dir_nxt;
      tmo_cnt    <= tmo_nxt;
    end
  end

endmodule

// File: doc/setup_editor.md
Name: setup_editor

Overview:
- Parametrised successor of the clock time-setup block. It edits a multi-field binary time word, e.g. {hh, mm, ss}, with per-field wrap limits.
- Controls: increment, decrement, auto-repeat, field advance, cancel and inactivity timeout.
- On completion it issues a one-cycle commit pulse (setup_imp), which the counter core uses to load setup_data.
- Sits between the button conditioning and the timekeeping counter; it is active only while rezhim equals MODE_SETUP.

Parameters:
FIELDS, 3, number of editable fields; field 0 occupies the LSBs (seconds).
FW, 8, width in bits of each field.
LIMITS, {8'd23,8'd59,8'd59}, packed FIELDS*FW vector of per-field maximum values; field i is at [i*FW +: FW].
MODE_SETUP, 2'd3, rezhim value that enables editing.
REPEAT_DELAY, 50_000_000, cycles a held inc/dec must stay asserted before the first auto-repeat step.
REPEAT_RATE, 10_000_000, cycles between subsequent auto-repeat steps.
TIMEOUT, 500_000_000, cycles of no button activity after which the edit is abandoned.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
data_ch  in  FIELDS*FW  live time from the counter core.
button  in  4  raw levels (debounced, asynchronous): [0] cancel, [1] inc, [2] next, [3] dec.
rezhim  in  2  display/operating mode.
setup_data  out  FIELDS*FW  edited time word.
setup_imp  out  1  one-cycle commit pulse.
field_sel  out  max(1,$clog2(FIELDS))  index of the field being edited (for display blink).
editing  out  1  high while in EDIT.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; setup_data=0, setup_imp=0, field_sel=0, editing=0; synchronisers, repeat counter and timeout counter all cleared.
- Button conditioning:
  - Each button passes through a 2-flop synchroniser, then a rising-edge detector.
  - A press is acted on at the 3rd rising clock edge after the raw input rises.
  - All FSM logic runs on clock only; no logic is clocked by a button.
- States:
  - IDLE: setup_data follows data_ch every cycle. If rezhim==MODE_SETUP, then on the next edge: setup_data<=data_ch, field_sel<=0, go to EDIT.
  - EDIT: editing=1. Actions apply to field f=field_sel; priority order is:
    1. rezhim!=MODE_SETUP -> IDLE, no pulse.
    2. cancel edge -> DONE, no pulse, setup_data held.
    3. next edge: if f<FIELDS-1 then field_sel<=f+1, else go to COMMIT.
    4. inc and dec both active in the same cycle -> no change.
    5. inc step: value>=LIMIT[f] -> 0, else value+1.
    6. dec step: value==0 -> LIMIT[f]; value>LIMIT[f] -> LIMIT[f]; else value-1.
    - Only field f changes; all other fields hold.
  - Auto-repeat:
    - While the synchronised inc (or dec) level stays high with the other low, one extra step occurs REPEAT_DELAY cycles after the edge step, then one every REPEAT_RATE cycles.
    - The repeat counter clears on release, on a field change and on leaving EDIT.
  - Timeout:
    - The counter clears on any synchronised button edge or repeat step and on entry to EDIT.
    - When it reaches TIMEOUT-1 -> DONE, no pulse.
  - COMMIT (one cycle): setup_imp=1, setup_data stable, go to DONE.
  - DONE: setup_data held, setup_imp=0. Go to IDLE when rezhim!=MODE_SETUP; this prevents immediate re-entry.
- setup_imp is high for exactly one cycle per completed edit and never in any other state.
- Out-of-range values loaded from data_ch are kept as-is until stepped; the inc/dec rules above then bring them back in range.
- Entry with rezhim already at MODE_SETUP after reset enters EDIT on the first edge after reset deasserts.
- Reset asserted mid-edit: immediate return to reset values, no pulse.

Test Plan:
1. Reset, then rezhim=3 with data_ch={23,59,58}: EDIT entered, setup_data={23,59,58}. One inc press -> {23,59,59}; another -> {23,59,0}; no carry into minutes.
2. dec on field 0 at value 0 -> 59. Advance to field 2 (two next presses) holding 0; dec -> 23; field_sel==2.
3. Edit to {12,34,56}, then three next presses: setup_imp high for exactly one cycle with setup_data={12,34,56}; state DONE; no further pulse while rezhim stays 3; rezhim=0 -> IDLE, setup_data tracks data_ch.
4. With REPEAT_DELAY=8 and REPEAT_RATE=4, hold inc for 20 cycles after the edge step: value +1 at the edge, then +1 at +8, +12, +16 and +20 -> total +5. Releasing stops stepping.
5. Cancel mid-edit, TIMEOUT=16 idle expiry, and rezhim changed to 1 mid-edit: each exits without a setup_imp pulse. inc+dec pressed together: value unchanged.
6. Assert reset during EDIT with setup_data={5,6,7}: all outputs 0 immediately (asynchronous); no pulse after release.
